// File: rtl/life_grid_engine.sv
// life_grid_engine: Conway's Game of Life (B3/S23) board core for a ROWS x COLS grid.
// Holds the board, loads a new one through a valid/ready port, and advances one
// generation per IDLE step or per PERIOD-cycle tick while run is held. Halts on
// still-life or extinction during free-run.
//   clk, reset         : clock, synchronous active-high reset
//   load_valid/_ready  : board load handshake; load_grid cell (r,c) at bit r*COLS+c
//   step, run          : single-generation request (IDLE only), free-run level
//   grid, gen_count    : current board and saturating generation count (registered)
//   busy, halted       : RUN / HALT state indicators
//   extinct, still     : combinational board status (grid==0, next(grid)==grid)
module life_grid_engine #(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned COLS   = 8,
  parameter int unsigned WRAP   = 0,
  parameter int unsigned PERIOD = 1,
  parameter int unsigned GEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_valid,
  input  logic [ROWS*COLS-1:0] load_grid,
  output logic                 load_ready,
  input  logic                 step,
  input  logic                 run,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 busy,
  output logic                 halted,
  output logic                 extinct,
  output logic                 still
);

  localparam int unsigned CELLS  = ROWS * COLS;
  localparam int unsigned TICK_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t              state;
  logic [TICK_W-1:0]   tick_cnt;
  logic [CELLS-1:0]    next_grid;
  logic [GEN_W-1:0]    gen_next;

  // Next-generation board: neighbour indices are resolved at elaboration time,
  // so each cell is just an 8-input population count plus the B3/S23 rule.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nb;
      logic [3:0] n;

      for (genvar k = 0; k < 8; k++) begin : g_nb
        // k enumerates the 8 neighbours: 0..2 row above, 3/4 left/right, 5..7 row below
        localparam int DR     = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
        localparam int DC     = (k < 3) ? (k - 1) : ((k == 3) ? -1 : ((k == 4) ? 1 : (k - 6)));
        localparam int NR     = int'(ROWS);
        localparam int NC     = int'(COLS);
        localparam int RR_RAW = r + DR;
        localparam int CC_RAW = c + DC;
        localparam bit INSIDE = (RR_RAW >= 0) && (RR_RAW < NR) && (CC_RAW >= 0) && (CC_RAW < NC);
        localparam int RR     = (RR_RAW + NR) % NR;
        localparam int CC     = (CC_RAW + NC) % NC;
        localparam int IDX    = RR * NC + CC;

        if ((WRAP != 0) || INSIDE) begin : g_live
          assign nb[k] = grid[IDX];
        end else begin : g_dead
          assign nb[k] = 1'b0;
        end
      end

      always_comb begin
        n = '0;
        for (int j = 0; j < 8; j++) begin
          n = n + 4'(nb[j]);
        end
      end

      assign next_grid[r*COLS+c] = (n == 4'd3) | ((n == 4'd2) & grid[r*COLS+c]);
    end
  end

  assign extinct    = (grid == '0);
  assign still      = (next_grid == grid);
  assign load_ready = (state != S_RUN);
  assign busy       = (state == S_RUN);
  assign halted     = (state == S_HALT);

  // Saturating generation increment
  assign gen_next = (gen_count == '1) ? gen_count : gen_count + GEN_W'(1);

  // Control FSM and board state; load wins over step/run in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      grid      <= '0;
      gen_count <= '0;
      tick_cnt  <= '0;
    end else if (load_valid && load_ready) begin
      state     <= S_IDLE;
      grid      <= load_grid;
      gen_count <= '0;
      tick_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (step) begin
            grid      <= next_grid;
            gen_count <= gen_next;
          end else if (run) begin
            state    <= S_RUN;
            tick_cnt <= '0;
          end
        end
        S_RUN: begin
          if (!run) begin
            state <= S_IDLE;
          end else if (tick_cnt == TICK_LAST) begin
            if (still || extinct) begin
              state <= S_HALT;
            end else begin
              grid      <= next_grid;
              gen_count <= gen_next;
              tick_cnt  <= '0;
            end
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
